// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: drives an external 4-bit rca one nibble per clock to add WIDTH-bit operands
module nibble_serial_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout_out,
    output logic [3:0]       add_i0,
    output logic [3:0]       add_i1,
    output logic             add_cin,
    input  logic [3:0]       add_o,
    input  logic             add_cout
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [KW-1:0]  k;
    logic [WIDTH-1:0] a_r, b_r;
    logic           c_r;
    logic           last;
    assign last    = k == KW'(NIB - 1);
    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign add_i0  = busy ? a_r[4*k +: 4] : 4'd0;
    assign add_i1  = busy ? b_r[4*k +: 4] : 4'd0;
    assign add_cin = busy ? c_r : 1'b0;
    // capture operands on start, then fold one rca result per cycle into sum
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= 1'b0;
            sum      <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r      <= a;
                    b_r      <= b;
                    c_r      <= cin_in;
                    sum      <= '0;
                    cout_out <= 1'b0;
                    k        <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    sum[4*k +: 4] <= add_o;
                    c_r           <= add_cout;
                    if (last) begin
                        cout_out <= add_cout;
                        state    <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// tb_nibble_serial_add_seq: directed and random checks of the nibble-serial adder sequencer
module tb_nibble_serial_add_seq;
    logic        clk = 1'b0;
    logic        reset, start, cin_in;
    logic [15:0] a, b;
    logic        busy, done, cout_out, add_cin, add_cout;
    logic [15:0] sum;
    logic [3:0]  add_i0, add_i1, add_o;
    int checks = 0;
    int failures = 0;

    nibble_serial_add_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin_in(cin_in),
        .busy(busy), .done(done), .sum(sum), .cout_out(cout_out),
        .add_i0(add_i0), .add_i1(add_i1), .add_cin(add_cin),
        .add_o(add_o), .add_cout(add_cout)
    );

    assign {add_cout, add_o} = add_i0 + add_i1 + add_cin;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input bit glitch);
        logic [16:0] exp_v, mask, carry;
        int nb;
        bit seen;
        exp_v = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
        a = ta; b = tb_; cin_in = tc; start = 1'b1;
        step;
        start = 1'b0;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) begin
                    mask  = (17'd1 << (4 * nb)) - 17'd1;
                    carry = (({1'b0, ta} & mask) + ({1'b0, tb_} & mask) + {16'd0, tc}) >> (4 * nb);
                    check("nib_i0", {28'd0, add_i0}, {28'd0, ta[4*nb +: 4]});
                    check("nib_i1", {28'd0, add_i1}, {28'd0, tb_[4*nb +: 4]});
                    check("nib_cin", {31'd0, add_cin}, {31'd0, carry[0]});
                    nb++;
                end
                start = glitch && nb == 2;
                if (start) a = 16'hAAAA;
                step;
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", nb, 32'd4);
        check("sum", {16'd0, sum}, {16'd0, exp_v[15:0]});
        check("cout", {31'd0, cout_out}, {31'd0, exp_v[16]});
        step;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sum_hold", {16'd0, sum}, {16'd0, exp_v[15:0]});
        check("idle_i0", {28'd0, add_i0}, 32'd0);
        if (glitch) begin
            step;
            check("not_queued", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int nd, first, prev;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin_in = 1'b0;
        step;
        step;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout_out}, 32'd0);
        check("rst_i0", {28'd0, add_i0}, 32'd0);
        check("rst_i1", {28'd0, add_i1}, 32'd0);
        check("rst_cin", {31'd0, add_cin}, 32'd0);
        reset = 1'b0;
        step;
        run_add(16'h1234, 16'h1111, 1'b0, 0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 0);
        run_add(16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_add(16'h0005, 16'h0003, 1'b0, 1);
        a = 16'h1357; b = 16'h2468; cin_in = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        check("k2_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout_out}, 32'd0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            nd += done;
            step;
        end
        check("abort_no_done", nd, 32'd0);
        run_add(16'h00FF, 16'h0001, 1'b0, 0);
        a = 16'h8000; b = 16'h8000; cin_in = 1'b0; start = 1'b1;
        nd = 0; first = -1; prev = 0;
        for (int i = 1; i <= 20; i++) begin
            step;
            if (done) begin
                if (first < 0) first = i;
                else check("hold_gap", i - prev, 32'd6);
                prev = i;
                nd++;
                check("hold_sum", {16'd0, sum}, 32'd0);
                check("hold_cout", {31'd0, cout_out}, 32'd1);
            end
        end
        check("hold_first", first, 32'd5);
        check("hold_count", nd, 32'd3);
        start = 1'b0;
        for (int i = 0; i < 8; i++) step;
        for (int n = 0; n < 25; n++) begin
            run_add(16'($urandom), 16'($urandom), 1'($urandom), 0);
            for (int g = $urandom_range(0, 3); g > 0; g--) step;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
